// File: rtl/clock_display_driver.sv
// Six-digit multiplexed common-anode 7-segment driver for an HH:MM:SS clock.
// Optional macro HOURS_BLANK_EN blanks the hours-tens digit when it is zero.
module clock_display_driver #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       frame_done
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

    localparam logic [6:0] SegBlank = 7'b1111111;
    localparam logic [6:0] SegDash  = 7'b0111111;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      dig_q, dig_d;
    logic [2:0]      dig_p_q;
    logic            live_q;
    logic [5:0]      sec_q, sec_d;
    logic [5:0]      min_q, min_d;
    logic [4:0]      hr_q, hr_d;
    logic [5:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            fd_q, fd_d;

    logic            cnt_wrap;
    logic            frame_start;
    logic [3:0]      sec_tens, sec_units, min_tens, min_units, hr_tens, hr_units;
    logic            sec_bad, min_bad, hr_bad;
    logic [6:0]      seg_sel;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = SegBlank;
        endcase
        return code;
    endfunction

    // Scan timing and frame-start snapshot
    always_comb begin
        cnt_wrap    = (cnt_q == CntMax);
        frame_start = (cnt_q == '0) && (dig_q == 3'd0);

        cnt_d = cnt_wrap ? '0 : cnt_q + CntW'(1);
        dig_d = dig_q;
        if (cnt_wrap) begin
            dig_d = (dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1;
        end

        sec_d = sec_q;
        min_d = min_q;
        hr_d  = hr_q;
        if (frame_start) begin
            sec_d = seconds;
            min_d = minutes;
            hr_d  = hours;
        end

        fd_d = cnt_wrap && (dig_q == 3'd5);
    end

    always_comb begin
        sec_tens  = 4'(sec_q / 6'd10);
        sec_units = 4'(sec_q % 6'd10);
        min_tens  = 4'(min_q / 6'd10);
        min_units = 4'(min_q % 6'd10);
        hr_tens   = 4'(hr_q / 5'd10);
        hr_units  = 4'(hr_q % 5'd10);
        sec_bad   = sec_q > 6'd59;
        min_bad   = min_q > 6'd59;
        hr_bad    = hr_q > 5'd23;
    end

    // Pixel stage trails dig_q by one cycle so it always reads a settled snapshot
    always_comb begin
        seg_sel = SegBlank;
        case (dig_p_q)
            3'd0: seg_sel = sec_bad ? SegDash : seg_code(sec_units);
            3'd1: seg_sel = sec_bad ? SegDash : seg_code(sec_tens);
            3'd2: seg_sel = min_bad ? SegDash : seg_code(min_units);
            3'd3: seg_sel = min_bad ? SegDash : seg_code(min_tens);
            3'd4: seg_sel = hr_bad  ? SegDash : seg_code(hr_units);
            3'd5: begin
                if (hr_bad) begin
                    seg_sel = SegDash;
                end else begin
`ifdef HOURS_BLANK_EN
                    seg_sel = (hr_tens == 4'd0) ? SegBlank : seg_code(hr_tens);
`else
                    seg_sel = seg_code(hr_tens);
`endif
                end
            end
            default: seg_sel = SegBlank;
        endcase

        an_d  = live_q ? ~(6'b000001 << dig_p_q) : 6'b111111;
        seg_d = live_q ? seg_sel : SegBlank;
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            dig_q   <= 3'd0;
            dig_p_q <= 3'd0;
            live_q  <= 1'b0;
            sec_q   <= 6'd0;
            min_q   <= 6'd0;
            hr_q    <= 5'd0;
            an_q    <= 6'b111111;
            seg_q   <= SegBlank;
            fd_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            dig_p_q <= dig_q;
            live_q  <= 1'b1;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hr_q    <= hr_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            fd_q    <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_clock_display_driver.sv
// Table-driven bench for clock_display_driver with SCAN_DIV=4: per-frame expectations are
// queued when a vector is applied and popped one per cycle against the pins.
module tb_clock_display_driver;

    localparam int unsigned ScanDiv = 4;
    localparam int unsigned FrameLen = 6 * ScanDiv;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;
`ifdef HOURS_BLANK_EN
    localparam logic [6:0] HZ = SB;
`else
    localparam logic [6:0] HZ = S0;
`endif

    typedef struct packed {
        logic [5:0]      sec;
        logic [5:0]      min;
        logic [4:0]      hr;
        logic [5:0][6:0] exp_seg;  // {digit5 .. digit0}
    } vec_t;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    logic       Clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] seconds = 6'd0;
    logic [5:0] minutes = 6'd0;
    logic [4:0] hours = 5'd0;
    logic [5:0] an;
    logic [6:0] seg;
    logic       frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];
    vec_t vecs[8];

    clock_display_driver #(.SCAN_DIV(ScanDiv)) dut (
        .Clk        (Clk),
        .reset_n    (reset_n),
        .seconds    (seconds),
        .minutes    (minutes),
        .hours      (hours),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        seconds = v.sec;
        minutes = v.min;
        hours   = v.hr;
    endtask

    // Called just after the frame-start edge that captured v; samples the 24 edges that follow.
    task automatic check_frame(input vec_t v, input int id);
        exp_t e;
        for (int i = 0; i < int'(FrameLen); i++) begin
            e.an  = ~(6'b000001 << (i / ScanDiv));
            e.seg = v.exp_seg[i / ScanDiv];
            e.fd  = (i == int'(FrameLen) - 2);
            sb.push_back(e);
        end
        for (int i = 0; i < int'(FrameLen); i++) begin
            @(posedge Clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("frame%0d cyc%0d an", id, i), 32'(an), 32'(e.an));
            chk($sformatf("frame%0d cyc%0d seg", id, i), 32'(seg), 32'(e.seg));
            chk($sformatf("frame%0d cyc%0d frame_done", id, i), 32'(frame_done), 32'(e.fd));
        end
    endtask

    initial begin
        vecs[0] = '{sec: 6'd56, min: 6'd34, hr: 5'd12, exp_seg: {S1, S2, S3, S4, S5, S6}};
        vecs[1] = '{sec: 6'd57, min: 6'd34, hr: 5'd12, exp_seg: {S1, S2, S3, S4, S5, S7}};
        vecs[2] = '{sec: 6'd60, min: 6'd34, hr: 5'd24, exp_seg: {SD, SD, S3, S4, SD, SD}};
        vecs[3] = '{sec: 6'd9,  min: 6'd0,  hr: 5'd7,  exp_seg: {HZ, S7, S0, S0, S0, S9}};
        vecs[4] = '{sec: 6'd59, min: 6'd59, hr: 5'd23, exp_seg: {S2, S3, S5, S9, S5, S9}};
        vecs[5] = '{sec: 6'd31, min: 6'd63, hr: 5'd31, exp_seg: {SD, SD, SD, SD, S3, S1}};
        vecs[6] = '{sec: 6'd0,  min: 6'd0,  hr: 5'd0,  exp_seg: {HZ, S0, S0, S0, S0, S0}};
        vecs[7] = '{sec: 6'd8,  min: 6'd47, hr: 5'd18, exp_seg: {S1, S8, S4, S7, S0, S8}};

        // Reset held with live inputs
        apply(vecs[0]);
        repeat (3) @(posedge Clk);
        #1;
        chk("reset an", 32'(an), 32'h3F);
        chk("reset seg", 32'(seg), 32'h7F);
        chk("reset frame_done", 32'(frame_done), 32'h0);

        @(negedge Clk);
        reset_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("edge1 an dark", 32'(an), 32'h3F);

        for (int v = 0; v < 7; v++) begin
            if (v < 6) apply(vecs[v + 1]);
            check_frame(vecs[v], v);
        end

        // Reset in the middle of digit 3
        repeat (14) @(posedge Clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midreset an", 32'(an), 32'h3F);
        chk("midreset seg", 32'(seg), 32'h7F);
        chk("midreset frame_done", 32'(frame_done), 32'h0);
        @(posedge Clk);
        #1;
        chk("midreset hold an", 32'(an), 32'h3F);

        apply(vecs[7]);
        @(negedge Clk);
        reset_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("restart edge1 an dark", 32'(an), 32'h3F);
        chk("restart edge1 seg blank", 32'(seg), 32'h7F);
        check_frame(vecs[7], 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
